// File: rtl/roubus_pkg.sv
// Shared roubus definitions: flit kind encodings, the kind-field helper and the
// ack bit that signals acceptance.
package roubus_pkg;

    localparam int unsigned KIND_W     = 2;
    localparam int unsigned ACK_W      = 3;
    localparam int unsigned ACK_ACCEPT = 0;

    typedef enum logic [KIND_W-1:0] {
        KIND_IDLE = 2'b00,
        KIND_WR   = 2'b01,
        KIND_RD   = 2'b10,
        KIND_RSP  = 2'b11
    } kind_e;

    // Callers pass the top KIND_W bits of a flit, i.e. flit[WID-1 -: KIND_W].
    function automatic kind_e to_kind(input logic [KIND_W-1:0] msbs);
        return kind_e'(msbs);
    endfunction

endpackage

// File: rtl/roubus_ord_fifo.sv
// Order FIFO of one-bit master ids. It records which master issued each
// outstanding read so that responses can be routed back in order.
module roubus_ord_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     push_id_i,
    input  logic                     pop_i,
    output logic                     head_id_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_id_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/roubus_arb2.sv
// Two-master round-robin arbiter in front of a single roubus target. Read
// responses return in order and are steered back through an id order FIFO.
module roubus_arb2
    import roubus_pkg::*;
#(
    parameter int unsigned DWID = 128,
    parameter int unsigned AWID = 32,
    parameter int unsigned CWID = 8,
    parameter int unsigned WID  = 2 + DWID + AWID + CWID,
    parameter int unsigned OSTD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WID-1:0]          m0_rou_in,
    output logic [ACK_W-1:0]        m0_ack_in,
    output logic [WID-1:0]          m0_rou_out,
    input  logic [ACK_W-1:0]        m0_ack_out,
    input  logic [WID-1:0]          m1_rou_in,
    output logic [ACK_W-1:0]        m1_ack_in,
    output logic [WID-1:0]          m1_rou_out,
    input  logic [ACK_W-1:0]        m1_ack_out,
    output logic [WID-1:0]          s_rou_out,
    input  logic [ACK_W-1:0]        s_ack_out,
    input  logic [WID-1:0]          s_rou_in,
    output logic [ACK_W-1:0]        s_ack_in,
    output logic [$clog2(OSTD):0]   ostd_cnt,
    output logic                    err_orphan
);

    kind_e          k0, k1, ks, kreq, krsp;
    logic [WID-1:0] req_q, req_d, rsp_q, rsp_d;
    logic           rsp_own_q, rsp_own_d;
    logic           rr_q, rr_d;
    logic           err_q, err_d;
    logic           fifo_full, fifo_empty, fifo_head;
    logic           push, pop, rd_room, el0, el1, load, g0, g1, own_ack, s_acc;
    logic           unused_ack_bits;

    assign k0   = to_kind(m0_rou_in[WID-1 -: KIND_W]);
    assign k1   = to_kind(m1_rou_in[WID-1 -: KIND_W]);
    assign ks   = to_kind(s_rou_in[WID-1 -: KIND_W]);
    assign kreq = to_kind(req_q[WID-1 -: KIND_W]);
    assign krsp = to_kind(rsp_q[WID-1 -: KIND_W]);

    assign unused_ack_bits = ^{m0_ack_out[ACK_W-1:1], m1_ack_out[ACK_W-1:1],
                               s_ack_out[ACK_W-1:1]};

    // Response acceptance; a pop this cycle frees a FIFO slot for a new read.
    always_comb begin
        own_ack = rsp_own_q ? m1_ack_out[ACK_ACCEPT] : m0_ack_out[ACK_ACCEPT];
        s_acc   = ((krsp == KIND_IDLE) || own_ack) && (ks == KIND_RSP);
        pop     = s_acc && !fifo_empty;
    end

    // Request eligibility and round-robin grant; rr_q=0 gives m0 priority.
    always_comb begin
        rd_room = !fifo_full || pop;
        el0     = (k0 != KIND_IDLE) && ((k0 != KIND_RD) || rd_room);
        el1     = (k1 != KIND_IDLE) && ((k1 != KIND_RD) || rd_room);
        load    = (kreq == KIND_IDLE) || s_ack_out[ACK_ACCEPT];
        g0      = load && el0 && (!el1 || !rr_q);
        g1      = load && el1 && (!el0 || rr_q);
        push    = (g0 && (k0 == KIND_RD)) || (g1 && (k1 == KIND_RD));
    end

    always_comb begin
        req_d     = req_q;
        rr_d      = rr_q;
        rsp_d     = rsp_q;
        rsp_own_d = rsp_own_q;
        err_d     = err_q;
        if (g0) begin
            req_d = m0_rou_in;
            rr_d  = 1'b1;
        end else if (g1) begin
            req_d = m1_rou_in;
            rr_d  = 1'b0;
        end else if (s_ack_out[ACK_ACCEPT]) begin
            req_d = '0;
        end
        if (pop) begin
            rsp_d     = s_rou_in;
            rsp_own_d = fifo_head;
        end else if (own_ack && (krsp != KIND_IDLE)) begin
            rsp_d = '0;
        end
        if (s_acc && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q     <= '0;
            rsp_q     <= '0;
            rsp_own_q <= 1'b0;
            rr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            req_q     <= req_d;
            rsp_q     <= rsp_d;
            rsp_own_q <= rsp_own_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
        end
    end

    roubus_ord_fifo #(.DEPTH(OSTD)) u_ord_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .push_id_i (g1),
        .pop_i     (pop),
        .head_id_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (ostd_cnt)
    );

    assign s_rou_out  = req_q;
    assign m0_rou_out = rsp_own_q ? '0 : rsp_q;
    assign m1_rou_out = rsp_own_q ? rsp_q : '0;
    assign m0_ack_in  = {2'b00, g0};
    assign m1_ack_in  = {2'b00, g1};
    assign s_ack_in   = {2'b00, s_acc};
    assign err_orphan = err_q;

endmodule

// File: tb/tb_roubus_arb2.sv
// Directed bench for roubus_arb2: arbitration order, read routing, FIFO-full
// blocking, target backpressure and orphan-response handling.
module tb_roubus_arb2;

    localparam int unsigned DWID = 128;
    localparam int unsigned AWID = 32;
    localparam int unsigned CWID = 8;
    localparam int unsigned WID  = 2 + DWID + AWID + CWID;
    localparam int unsigned OSTD = 8;
    localparam int unsigned VW   = 256;

    localparam logic [1:0] K_WR  = 2'b01;
    localparam logic [1:0] K_RD  = 2'b10;
    localparam logic [1:0] K_RSP = 2'b11;

    logic           clk, rst_n;
    logic [WID-1:0] m0_rou_in, m0_rou_out, m1_rou_in, m1_rou_out;
    logic [WID-1:0] s_rou_out, s_rou_in;
    logic [2:0]     m0_ack_in, m0_ack_out, m1_ack_in, m1_ack_out;
    logic [2:0]     s_ack_out, s_ack_in;
    logic [3:0]     ostd_cnt;
    logic           err_orphan;

    int checks = 0;
    int errors = 0;

    roubus_arb2 #(
        .DWID(DWID), .AWID(AWID), .CWID(CWID), .WID(WID), .OSTD(OSTD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_rou_in  (m0_rou_in),
        .m0_ack_in  (m0_ack_in),
        .m0_rou_out (m0_rou_out),
        .m0_ack_out (m0_ack_out),
        .m1_rou_in  (m1_rou_in),
        .m1_ack_in  (m1_ack_in),
        .m1_rou_out (m1_rou_out),
        .m1_ack_out (m1_ack_out),
        .s_rou_out  (s_rou_out),
        .s_ack_out  (s_ack_out),
        .s_rou_in   (s_rou_in),
        .s_ack_in   (s_ack_in),
        .ostd_cnt   (ostd_cnt),
        .err_orphan (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WID-1:0] fl(input logic [1:0] k, input logic [31:0] p);
        return {k, (WID-2)'(p)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        m0_rou_in  = '0;
        m1_rou_in  = '0;
        s_rou_in   = '0;
        m0_ack_out = '0;
        m1_ack_out = '0;
        s_ack_out  = '0;
        step();
        step();
        chk("rst_s_out",  VW'(s_rou_out),  VW'(0));
        chk("rst_m0_out", VW'(m0_rou_out), VW'(0));
        chk("rst_m1_out", VW'(m1_rou_out), VW'(0));
        chk("rst_ostd",   VW'(ostd_cnt),   VW'(0));
        chk("rst_err",    VW'(err_orphan), VW'(0));
        rst_n = 1'b1;
        step();
        chk("idle_s_out",  VW'(s_rou_out), VW'(0));
        chk("idle_m0_ack", VW'(m0_ack_in), VW'(0));
        chk("idle_m1_ack", VW'(m1_ack_in), VW'(0));
        chk("idle_s_ack",  VW'(s_ack_in),  VW'(0));
        chk("idle_ostd",   VW'(ostd_cnt),  VW'(0));

        // Four writes per master, target always accepting: strict alternation.
        s_ack_out = 3'b001;
        for (int k = 0; k < 8; k++) begin
            m0_rou_in = (k < 7) ? fl(K_WR, 32'hA0 + 32'((k + 1) / 2)) : '0;
            m1_rou_in = fl(K_WR, 32'hB0 + 32'(k / 2));
            #1;
            chk("wr_m0_ack", VW'(m0_ack_in), VW'((k % 2 == 0) ? 1 : 0));
            chk("wr_m1_ack", VW'(m1_ack_in), VW'((k % 2 == 1) ? 1 : 0));
            step();
            chk("wr_s_out", VW'(s_rou_out),
                VW'((k % 2 == 0) ? fl(K_WR, 32'hA0 + 32'(k / 2))
                                 : fl(K_WR, 32'hB0 + 32'(k / 2))));
            chk("wr_ostd", VW'(ostd_cnt), VW'(0));
        end
        m0_rou_in = '0;
        m1_rou_in = '0;
        step();
        chk("wr_drained", VW'(s_rou_out), VW'(0));

        // m1 reads 0x10, m0 reads 0x20; responses come back in order.
        m1_rou_in = fl(K_RD, 32'h10);
        #1;
        chk("rd1_m1_ack", VW'(m1_ack_in), VW'(1));
        step();
        m1_rou_in = '0;
        m0_rou_in = fl(K_RD, 32'h20);
        chk("rd1_s_out", VW'(s_rou_out), VW'(fl(K_RD, 32'h10)));
        chk("rd1_ostd",  VW'(ostd_cnt),  VW'(1));
        #1;
        chk("rd2_m0_ack", VW'(m0_ack_in), VW'(1));
        step();
        m0_rou_in = '0;
        chk("rd2_s_out", VW'(s_rou_out), VW'(fl(K_RD, 32'h20)));
        chk("rd2_ostd",  VW'(ostd_cnt),  VW'(2));
        s_rou_in = fl(K_RSP, 32'hD1);
        #1;
        chk("rsp1_s_ack", VW'(s_ack_in), VW'(1));
        step();
        s_rou_in = fl(K_RSP, 32'hD2);
        chk("rsp1_m1_out", VW'(m1_rou_out), VW'(fl(K_RSP, 32'hD1)));
        chk("rsp1_m0_out", VW'(m0_rou_out), VW'(0));
        chk("rsp1_ostd",   VW'(ostd_cnt),   VW'(1));
        #1;
        chk("rsp2_blocked", VW'(s_ack_in), VW'(0));
        m1_ack_out = 3'b001;
        #1;
        chk("rsp2_s_ack", VW'(s_ack_in), VW'(1));
        step();
        s_rou_in   = '0;
        m1_ack_out = '0;
        chk("rsp2_m0_out", VW'(m0_rou_out), VW'(fl(K_RSP, 32'hD2)));
        chk("rsp2_m1_out", VW'(m1_rou_out), VW'(0));
        chk("rsp2_ostd",   VW'(ostd_cnt),   VW'(0));
        m0_ack_out = 3'b001;
        step();
        m0_ack_out = '0;
        chk("rsp2_cleared", VW'(m0_rou_out), VW'(0));

        // m0 fills the order FIFO; the ninth read must wait, m1 writes pass.
        for (int k = 0; k < 8; k++) begin
            m0_rou_in = fl(K_RD, 32'h100 + 32'(k));
            #1;
            chk("full_m0_ack", VW'(m0_ack_in), VW'(1));
            step();
        end
        chk("full_ostd", VW'(ostd_cnt), VW'(8));
        m0_rou_in = fl(K_RD, 32'h108);
        m1_rou_in = fl(K_WR, 32'hC0);
        #1;
        chk("full_m0_held", VW'(m0_ack_in), VW'(0));
        chk("full_m1_wr",   VW'(m1_ack_in), VW'(1));
        step();
        m1_rou_in = '0;
        chk("full_s_out", VW'(s_rou_out), VW'(fl(K_WR, 32'hC0)));
        chk("full_ostd2", VW'(ostd_cnt),  VW'(8));
        #1;
        chk("full_m0_held2", VW'(m0_ack_in), VW'(0));
        step();
        // First response frees a slot in the same cycle the ninth read is taken.
        s_rou_in   = fl(K_RSP, 32'hE00);
        m0_ack_out = 3'b001;
        #1;
        chk("pop_m0_ack", VW'(m0_ack_in), VW'(1));
        chk("pop_s_ack",  VW'(s_ack_in),  VW'(1));
        step();
        m0_rou_in = '0;
        chk("pop_ostd",   VW'(ostd_cnt),   VW'(8));
        chk("pop_m0_out", VW'(m0_rou_out), VW'(fl(K_RSP, 32'hE00)));
        chk("pop_s_out",  VW'(s_rou_out),  VW'(fl(K_RD, 32'h108)));
        for (int j = 1; j <= 8; j++) begin
            s_rou_in = fl(K_RSP, 32'hE00 + 32'(j));
            step();
            chk("drain_m0_out", VW'(m0_rou_out), VW'(fl(K_RSP, 32'hE00 + 32'(j))));
            chk("drain_m1_out", VW'(m1_rou_out), VW'(0));
            chk("drain_ostd",   VW'(ostd_cnt),   VW'(8 - j));
        end
        s_rou_in = '0;
        step();
        m0_ack_out = '0;
        chk("drain_done", VW'(m0_rou_out), VW'(0));
        chk("drain_ostd0", VW'(ostd_cnt), VW'(0));

        // Target backpressure: REQ must hold and no master may be acked.
        s_ack_out = '0;
        m0_rou_in = fl(K_WR, 32'hD0);
        m1_rou_in = fl(K_WR, 32'hE0);
        #1;
        chk("stall_m1_ack", VW'(m1_ack_in), VW'(1));
        chk("stall_m0_ack", VW'(m0_ack_in), VW'(0));
        step();
        m1_rou_in = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_hold_ack", VW'(m0_ack_in), VW'(0));
            chk("stall_hold_out", VW'(s_rou_out), VW'(fl(K_WR, 32'hE0)));
            step();
        end
        s_ack_out = 3'b001;
        #1;
        chk("stall_resume_ack", VW'(m0_ack_in), VW'(1));
        step();
        m0_rou_in = '0;
        chk("stall_resume_out", VW'(s_rou_out), VW'(fl(K_WR, 32'hD0)));
        step();
        chk("stall_empty", VW'(s_rou_out), VW'(0));

        // Orphan response: accepted and dropped, sticky error until reset.
        s_rou_in = fl(K_RSP, 32'hEE);
        #1;
        chk("orph_s_ack", VW'(s_ack_in), VW'(1));
        step();
        s_rou_in = '0;
        chk("orph_err",    VW'(err_orphan), VW'(1));
        chk("orph_m0_out", VW'(m0_rou_out), VW'(0));
        chk("orph_m1_out", VW'(m1_rou_out), VW'(0));
        step();
        chk("orph_sticky", VW'(err_orphan), VW'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("orph_reset", VW'(err_orphan), VW'(0));
        chk("final_ostd", VW'(ostd_cnt),   VW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/roubus_arb2.md
Name: roubus_arb2

Overview:
- Two-requester arbiter that shares one roubus memory target (ram model or RTL RAM) between two masters.
- Request flits from m0/m1 are merged round-robin onto the single target request channel.
- Read responses return in order and are routed back to the issuing master using an internal order FIFO.
- Sits between bus masters/testbench agents and a ram instance.

Parameters:
- DWID, 128, data field width
- AWID, 32, address field width
- CWID, 8, command/tag field width
- WID, 2+DWID+AWID+CWID, flit width
- OSTD, 8, max outstanding reads (order FIFO depth, power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- m0_rou_in  in  WID  master0 request flit
- m0_ack_in  out  3  accept for m0_rou_in
- m0_rou_out  out  WID  response flit to master0
- m0_ack_out  in  3  master0 accepts response
- m1_rou_in / m1_ack_in / m1_rou_out / m1_ack_out: same as m0, for master1
- s_rou_out  out  WID  request flit to target
- s_ack_out  in  3  target accepts request
- s_rou_in  in  WID  response flit from target
- s_ack_in  out  3  accept for s_rou_in
- ostd_cnt  out  $clog2(OSTD)+1  reads in flight
- err_orphan  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Flit kind = flit[WID-1:WID-2]:
  - 00 idle
  - 01 write (no response)
  - 10 read
  - 11 response
- A flit transfers in a cycle where kind!=00 and receiver's ack[0]=1. ack[2:1] are always driven 0.
- Reset (rst_n=0 at posedge): all rou_out regs = 0, acks = 0, rr pointer = m0 priority, FIFO empty, ostd_cnt = 0, err_orphan = 0. Reset mid-transfer drops all in-flight state; no flit is replayed.
- Request path:
  - One-entry output register REQ drives s_rou_out.
  - REQ is loadable when empty or when s_ack_out[0]=1 this cycle.
  - Eligible master: kind!=00, and if kind==10 the FIFO is not full (counting a same-cycle pop).
  - If loadable and ≥1 eligible master: grant per round-robin. Granted master gets mX_ack_in[0]=1 combinationally; REQ <= its flit next edge. Latency is 1 cycle input→s_rou_out.
  - rr pointer moves to the other master after each grant. With both masters requesting every cycle, grants alternate m0,m1,m0…
  - Not loadable or no eligible master: no ack; REQ holds (cleared to idle when accepted without reload).
  - A granted read pushes the master id (0/1) into the FIFO in the same cycle.
- Response path:
  - One-entry register RSP, routed by FIFO head.
  - s_ack_in[0]=1 when RSP is empty or its owner acks this cycle, and s_rou_in kind==11.
  - On accept: RSP <= flit, owner = FIFO head, FIFO pop. The flit is driven only on the owner's mX_rou_out; the other master's output is 0.
  - RSP clears when the owner acks and nothing new is accepted.
  - Response with FIFO empty: still acked (dropped), err_orphan <= 1 (sticky until reset), no pop.
  - Response with kind!=11: ignored, no ack.
- ostd_cnt = FIFO occupancy. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo OSTD.
- FIFO full: reads blocked, writes from the same master still eligible. Round-robin skips a blocked master without moving the pointer onto it.

Decomposition:
- Shared package roubus_pkg: KIND_IDLE/WR/RD/RSP constants, kind field slice helper, ACK_ACCEPT bit index.
- One sub-module: roubus_ord_fifo (id-bit FIFO, depth OSTD, push/pop/full/empty/count).

Test Plan:
- Reset, then both masters idle → all outputs 0, ostd_cnt=0, s_rou_out idle.
- m0 and m1 both issue 4 writes back-to-back, target always acks → s_rou_out order m0,m1,m0,m1…; each master acked every other cycle; ostd_cnt stays 0.
- m1 reads A=0x10, then m0 reads A=0x20, ram replies in order D1,D2 → D1 on m1_rou_out, D2 on m0_rou_out; ostd_cnt goes 0→1→2→1→0.
- m0 issues 9 reads with OSTD=8 and no responses → 8 accepted, 9th held (m0_ack_in[0]=0); m1 write in the same window still accepted.
- Target holds s_ack_out[0]=0 for 5 cycles → REQ stable; no master acked; flow resumes without loss or duplication.
- Inject kind=11 on s_rou_in with FIFO empty → s_ack_in[0]=1, err_orphan=1, both mX_rou_out stay 0. Then assert rst_n=0 for one cycle → err_orphan=0.
